// File: rtl/mem_responder.sv
// Memory-side responder for the pipeline memory stage.
// Accepts one load/store at a time, waits a fixed latency, then returns
// read data or a store acknowledge. Owns a word-addressed 16-bit array.
module mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [3:0]    cnt_r;
  logic          cap_we_r;
  logic [15:0]   cap_addr_r;
  logic [15:0]   cap_wdata_r;
  logic [15:0]   mem_r [DEPTH];
  logic          req_ready_r;
  logic [15:0]   resp_rdata_r;
  logic          resp_err_r;

  logic          accept_s;
  logic          wait_done_s;
  logic          enter_resp_s;
  logic          resp_hs_s;
  logic          acc_we_s;
  logic [15:0]   acc_addr_s;
  logic [15:0]   acc_wdata_s;
  logic          in_range_s;
  logic [AW-1:0] mem_idx_s;

  assign accept_s     = (state_r == ST_IDLE) && req_valid && req_ready_r && !halt_sys;
  // cnt_r holds the remaining WAIT cycles; the last one moves us to RESP
  assign wait_done_s  = (state_r == ST_WAIT) && !halt_sys && (cnt_r <= 4'd1);
  assign enter_resp_s = (accept_s && (LATENCY == 1)) || wait_done_s;
  assign resp_hs_s    = (state_r == ST_RESP) && resp_ready && !halt_sys;

  // Select the request the memory access acts on: live inputs when RESP is
  // entered straight from IDLE (LATENCY of 1), the captured copy otherwise
  always_comb begin
    if (state_r == ST_IDLE) begin
      acc_we_s    = req_we;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
    end else begin
      acc_we_s    = cap_we_r;
      acc_addr_s  = cap_addr_r;
      acc_wdata_s = cap_wdata_r;
    end
  end

  assign in_range_s = ({1'b0, acc_addr_s} < 17'(DEPTH));
  assign mem_idx_s  = acc_addr_s[AW-1:0];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; halt_sys freezes every transition
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = (LATENCY > 1) ? ST_WAIT : ST_RESP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_done_s) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_hs_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Outputs: resp_valid follows the state, stall is the only input-driven path
  always_comb begin
    req_ready  = req_ready_r;
    resp_valid = (state_r == ST_RESP);
    resp_rdata = resp_rdata_r;
    resp_err   = resp_err_r;
    stall      = (req_valid && !req_ready_r) || (state_r != ST_IDLE);
  end

  // Ready is registered: high whenever the coming cycle is an unhalted IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready_r <= 1'b0;
    end else begin
      req_ready_r <= (state_next_s == ST_IDLE) && !halt_sys;
    end
  end

  // Request capture and latency countdown (frozen while halted)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r       <= 4'd0;
      cap_we_r    <= 1'b0;
      cap_addr_r  <= 16'h0000;
      cap_wdata_r <= 16'h0000;
    end else if (accept_s) begin
      cnt_r       <= 4'(LATENCY - 1);
      cap_we_r    <= req_we;
      cap_addr_r  <= req_addr;
      cap_wdata_r <= req_wdata;
    end else if ((state_r == ST_WAIT) && !halt_sys && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Data array: cleared on reset, store commits only on the edge entering RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else if (enter_resp_s && acc_we_s && in_range_s) begin
      mem_r[mem_idx_s] <= acc_wdata_s;
    end else begin
      mem_r[mem_idx_s] <= mem_r[mem_idx_s];
    end
  end

  // Response data/error: loaded on entering RESP, held until the handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_rdata_r <= 16'h0000;
      resp_err_r   <= 1'b0;
    end else if (enter_resp_s) begin
      resp_err_r   <= !in_range_s;
      resp_rdata_r <= (!acc_we_s && in_range_s) ? mem_r[mem_idx_s] : 16'h0000;
    end else if (resp_hs_s) begin
      resp_rdata_r <= 16'h0000;
      resp_err_r   <= 1'b0;
    end else begin
      resp_rdata_r <= resp_rdata_r;
      resp_err_r   <= resp_err_r;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2 instance for the main
// sequence and a LATENCY=1 instance for back-to-back traffic.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_sys;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err, stall;
  logic [15:0] resp_rdata;

  logic        l1_halt_sys;
  logic        l1_req_valid, l1_req_ready, l1_req_we;
  logic [15:0] l1_req_addr, l1_req_wdata;
  logic        l1_resp_valid, l1_resp_ready, l1_resp_err, l1_stall;
  logic [15:0] l1_resp_rdata;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] rd;
  logic        er;
  int          lat;

  mem_responder #(.LATENCY(2), .DEPTH(256)) u_dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall)
  );

  mem_responder #(.LATENCY(1), .DEPTH(256)) u_dut1 (
    .clk(clk), .rst(rst), .halt_sys(l1_halt_sys),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_we(l1_req_we),
    .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
    .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
    .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err), .stall(l1_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance, starting in a ready cycle
  task automatic xact(input logic we, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] rdo, output logic ero, output int lato);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    lato = 1;
    while (!resp_valid && lato < 40) begin
      tick();
      lato++;
    end
    rdo = resp_rdata;
    ero = resp_err;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; halt_sys = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
    resp_ready = 1'b0;
    l1_halt_sys = 1'b0; l1_req_valid = 1'b0; l1_req_we = 1'b0;
    l1_req_addr = 16'h0000; l1_req_wdata = 16'h0000; l1_resp_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_req_ready", {15'd0, req_ready}, 16'h0000);
    chk("rst_resp_valid", {15'd0, resp_valid}, 16'h0000);
    chk("rst_rdata", resp_rdata, 16'h0000);
    chk("rst_err", {15'd0, resp_err}, 16'h0000);
    chk("rst_stall", {15'd0, stall}, 16'h0000);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", {15'd0, req_ready}, 16'h0001);

    // Store BEEF to 0x10 with an explicit cycle-by-cycle view
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 16'hBEEF;
    #1;
    chk("st_c0_stall", {15'd0, stall}, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("st_c1_valid", {15'd0, resp_valid}, 16'h0000);
    chk("st_c1_ready", {15'd0, req_ready}, 16'h0000);
    chk("st_c1_stall", {15'd0, stall}, 16'h0001);
    tick();
    chk("st_c2_valid", {15'd0, resp_valid}, 16'h0001);
    chk("st_c2_err", {15'd0, resp_err}, 16'h0000);
    chk("st_c2_rdata", resp_rdata, 16'h0000);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("st_c3_valid", {15'd0, resp_valid}, 16'h0000);
    chk("st_c3_ready", {15'd0, req_ready}, 16'h0001);

    // Load 0x10 with 5 cycles of backpressure and a competing store held up
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    tick();
    req_we = 1'b1; req_addr = 16'h0030; req_wdata = 16'hAAAA;
    #1;
    chk("bp_wait_valid", {15'd0, resp_valid}, 16'h0000);
    chk("bp_wait_stall", {15'd0, stall}, 16'h0001);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {15'd0, resp_valid}, 16'h0001);
      chk("bp_rdata", resp_rdata, 16'hBEEF);
      chk("bp_ready", {15'd0, req_ready}, 16'h0000);
      chk("bp_stall", {15'd0, stall}, 16'h0001);
      tick();
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    #1;
    chk("bp_still_valid", {15'd0, resp_valid}, 16'h0001);
    tick();
    resp_ready = 1'b0;
    chk("bp_done_valid", {15'd0, resp_valid}, 16'h0000);
    xact(1'b0, 16'h0030, 16'h0000, rd, er, lat);
    chk("bp_no_accept_rdata", rd, 16'h0000);

    // Load latency and boundary address 0xFF
    xact(1'b0, 16'h0010, 16'h0000, rd, er, lat);
    chk("ld_lat", 16'(lat), 16'd2);
    chk("ld_rdata", rd, 16'hBEEF);
    xact(1'b1, 16'h00FF, 16'h5A5A, rd, er, lat);
    chk("st_ff_err", {15'd0, er}, 16'h0000);
    xact(1'b0, 16'h00FF, 16'h0000, rd, er, lat);
    chk("ld_ff_rdata", rd, 16'h5A5A);

    // Out of range
    xact(1'b1, 16'h0100, 16'h1234, rd, er, lat);
    chk("oor_st_err", {15'd0, er}, 16'h0001);
    chk("oor_st_lat", 16'(lat), 16'd2);
    xact(1'b0, 16'h0000, 16'h0000, rd, er, lat);
    chk("oor_ld0_rdata", rd, 16'h0000);
    chk("oor_ld0_err", {15'd0, er}, 16'h0000);
    xact(1'b0, 16'h0100, 16'h0000, rd, er, lat);
    chk("oor_ld_rdata", rd, 16'h0000);
    chk("oor_ld_err", {15'd0, er}, 16'h0001);

    // Halt for cycles 1..3 after acceptance; response in cycle 5
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0040; req_wdata = 16'h7777;
    tick();
    req_valid = 1'b0; halt_sys = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk("halt_valid", {15'd0, resp_valid}, 16'h0000);
      chk("halt_ready", {15'd0, req_ready}, 16'h0000);
      tick();
    end
    halt_sys = 1'b0;
    chk("halt_c4_valid", {15'd0, resp_valid}, 16'h0000);
    tick();
    chk("halt_c5_valid", {15'd0, resp_valid}, 16'h0001);
    halt_sys = 1'b1; resp_ready = 1'b1;
    tick();
    chk("halt_hs_ignored", {15'd0, resp_valid}, 16'h0001);
    halt_sys = 1'b0;
    tick();
    resp_ready = 1'b0;
    chk("halt_hs_done", {15'd0, resp_valid}, 16'h0000);
    xact(1'b0, 16'h0040, 16'h0000, rd, er, lat);
    chk("halt_ld_rdata", rd, 16'h7777);

    // Reset in the middle of a store
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'hCAFE;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_ready", {15'd0, req_ready}, 16'h0000);
    chk("mrst_valid", {15'd0, resp_valid}, 16'h0000);
    chk("mrst_stall", {15'd0, stall}, 16'h0000);
    chk("mrst_rdata", resp_rdata, 16'h0000);
    #3;
    rst = 1'b1;
    tick();
    chk("mrst_post_ready", {15'd0, req_ready}, 16'h0001);
    xact(1'b0, 16'h0020, 16'h0000, rd, er, lat);
    chk("mrst_ld20", rd, 16'h0000);
    xact(1'b0, 16'h0010, 16'h0000, rd, er, lat);
    chk("mrst_ld10_cleared", rd, 16'h0000);

    // LATENCY=1 instance: store then continuous loads, response every 2 cycles
    l1_req_valid = 1'b1; l1_req_we = 1'b1; l1_req_addr = 16'h0005; l1_req_wdata = 16'h1111;
    #1;
    chk("l1_ready", {15'd0, l1_req_ready}, 16'h0001);
    tick();
    chk("l1_st_valid", {15'd0, l1_resp_valid}, 16'h0001);
    chk("l1_st_err", {15'd0, l1_resp_err}, 16'h0000);
    chk("l1_st_stall", {15'd0, l1_stall}, 16'h0001);
    l1_req_we = 1'b0;
    tick();
    chk("l1_idle_valid", {15'd0, l1_resp_valid}, 16'h0000);
    chk("l1_idle_ready", {15'd0, l1_req_ready}, 16'h0001);
    tick();
    chk("l1_ld_valid", {15'd0, l1_resp_valid}, 16'h0001);
    chk("l1_ld_rdata", l1_resp_rdata, 16'h1111);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("l1_b2b_valid", {15'd0, l1_resp_valid}, (i % 2 == 0) ? 16'h0000 : 16'h0001);
      if (i % 2 == 1) begin
        chk("l1_b2b_rdata", l1_resp_rdata, 16'h1111);
      end else begin
        chk("l1_b2b_ready", {15'd0, l1_req_ready}, 16'h0001);
      end
    end
    l1_req_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the pipeline's memory stage.
- Accepts one load or store request at a time over a valid/ready handshake, models a fixed access latency, then returns read data or a write acknowledge over a second valid/ready handshake.
- Drives a stall indication back toward the pipeline while a request is outstanding.
- Holds its own word-addressed data array.

Parameters:
- LATENCY, 2, cycles from request acceptance to resp_valid assertion; legal range 1..15.
- DEPTH, 256, number of 16-bit words in the data array; power of two, 2..65536.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- halt_sys  in  1  global halt; freezes the block.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  16  word address.
- req_wdata  in  16  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  16  load data; 16'h0000 for stores and errors.
- resp_err  out  1  address was out of range (req_addr >= DEPTH).
- stall  out  1  pipeline must hold.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, latency counter=0, captured request cleared.
  - req_ready=0 while rst=0.
  - resp_valid=0, resp_rdata=16'h0000, resp_err=0, stall=0.
  - Every array word cleared to 16'h0000.
  - Reset mid-transaction abandons the transaction; no write commits.
  - After release, req_ready=1 in the first cycle.
- State machine:
  - IDLE: req_ready=1. On req_valid && req_ready && !halt_sys at edge N:
    - capture we/addr/wdata.
    - load counter with LATENCY-1.
    - go to WAIT if LATENCY>1, otherwise go directly to RESP.
  - WAIT: req_ready=0. Counter decrements each non-halted cycle. When the counter reaches 0, go to RESP at the next edge.
  - Net latency: resp_valid is first high in cycle N+LATENCY.
  - RESP: resp_valid=1; resp_rdata and resp_err are stable and held until resp_valid && resp_ready is sampled at an edge, then return to IDLE.
  - There is no bypass: a new request can be accepted only in the cycle after the response handshake. Single outstanding request.
- Memory access:
  - A store commits to the array on the edge that enters RESP, not on acceptance.
  - A load samples the array on that same edge.
  - Out-of-range address (addr >= DEPTH): store dropped, load returns 16'h0000, resp_err=1. Otherwise resp_err=0.
  - Addresses do not wrap.
- stall:
  - stall = (req_valid && !req_ready) || (state != IDLE).
  - Combinational from state and req_valid.
- halt_sys=1:
  - No acceptance; req_ready is forced to 0.
  - Counter frozen; no array write.
  - resp_valid and resp_rdata hold their current values.
  - A response handshake is ignored: the block stays in RESP.
  - Deasserting halt_sys resumes with the remaining count unchanged.
- Simultaneous events:
  - resp_ready while in IDLE or WAIT is ignored.
  - req_valid while in WAIT or RESP is not accepted; the requester must hold its request stable.
- Timing: req_ready, resp_valid, resp_rdata and resp_err are registered/state-derived outputs. stall is the only output with a combinational path from an input.

Test Plan:
- Store then load: store addr 16'h0010, data 16'hBEEF accepted at cycle 0, resp_ready=1 → resp_valid in cycle 2 with resp_err=0. Then load addr 16'h0010 → resp_rdata=16'hBEEF exactly LATENCY cycles after acceptance.
- Backpressure: load addr 16'h0010 with resp_ready=0 for 5 cycles → resp_valid and resp_rdata=16'hBEEF held. req_ready=0 and stall=1 throughout. A second req_valid during this time is not accepted.
- Out of range: store addr 16'h0100 (DEPTH=256) data 16'h1234 → resp_err=1. A following load of addr 16'h0000 returns 16'h0000. A load of 16'h0100 returns resp_rdata=16'h0000, resp_err=1.
- Halt: halt_sys=1 for 3 cycles starting in the cycle after acceptance (LATENCY=2) → resp_valid first high in cycle 5. No array change during the halt.
- Reset mid-operation: store to addr 16'h0020 accepted, rst=0 asserted in the next cycle → all outputs at reset values immediately. After release, a load of addr 16'h0020 returns 16'h0000 and req_ready=1.
- LATENCY=1 build: back-to-back loads with resp_ready tied to 1 → a response every 2 cycles, state sequence IDLE→RESP→IDLE.
